// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving CPU port A and loader port B shared access to a byte memory.
// Read acks on the third edge counting the grant edge, write acks on the second; outputs registered.
module mem_arbiter #(
  parameter int addr_width = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [addr_width-1:0] a_addr,
  input  logic [7:0]            a_wdata,
  output logic                  a_ack,
  output logic [7:0]            a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [addr_width-1:0] b_addr,
  input  logic [7:0]            b_wdata,
  output logic                  b_ack,
  output logic [7:0]            b_rdata,
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic                  mem_write,
  output logic [7:0]            mem_data_in,
  input  logic [7:0]            mem_data_out,
  output logic                  busy,
  output logic                  grant_b
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA, WR} state_t;

  state_t                state_q, state_d;
  logic                  a_ack_q, a_ack_d;
  logic                  b_ack_q, b_ack_d;
  logic [7:0]            a_rdata_q, a_rdata_d;
  logic [7:0]            b_rdata_q, b_rdata_d;
  logic [addr_width-1:0] mem_raddr_q, mem_raddr_d;
  logic [addr_width-1:0] mem_waddr_q, mem_waddr_d;
  logic                  mem_write_q, mem_write_d;
  logic [7:0]            mem_data_in_q, mem_data_in_d;
  logic                  busy_q, busy_d;
  logic                  grant_b_q, grant_b_d;

  logic                  elig_a, elig_b, grant, win_b, win_we;
  logic [addr_width-1:0] win_addr;
  logic [7:0]            win_wdata;

  // A port still seeing its own ack is finishing, not asking again.
  always_comb begin
    elig_a    = a_req & ~a_ack_q;
    elig_b    = b_req & ~b_ack_q;
    grant     = elig_a | elig_b;
    win_b     = elig_b & (~elig_a | ~grant_b_q);
    win_we    = win_b ? b_we    : a_we;
    win_addr  = win_b ? b_addr  : a_addr;
    win_wdata = win_b ? b_wdata : a_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = win_we ? WR : RD_WAIT;
      RD_WAIT: state_d = RD_DATA;
      RD_DATA: state_d = IDLE;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_ack_d       = 1'b0;
    b_ack_d       = 1'b0;
    mem_write_d   = 1'b0;
    a_rdata_d     = a_rdata_q;
    b_rdata_d     = b_rdata_q;
    mem_raddr_d   = mem_raddr_q;
    mem_waddr_d   = mem_waddr_q;
    mem_data_in_d = mem_data_in_q;
    grant_b_d     = grant_b_q;
    busy_d        = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (grant) begin
          grant_b_d = win_b;
          if (win_we) begin
            mem_waddr_d   = win_addr;
            mem_data_in_d = win_wdata;
          end else begin
            mem_raddr_d = win_addr;
          end
        end
      end
      // grant_b_q still names the port being served until the next grant.
      RD_DATA: begin
        if (grant_b_q) begin
          b_rdata_d = mem_data_out;
          b_ack_d   = 1'b1;
        end else begin
          a_rdata_d = mem_data_out;
          a_ack_d   = 1'b1;
        end
      end
      WR: begin
        mem_write_d = 1'b1;
        if (grant_b_q) b_ack_d = 1'b1;
        else           a_ack_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
      mem_raddr_q   <= '0;
      mem_waddr_q   <= '0;
      mem_write_q   <= 1'b0;
      mem_data_in_q <= '0;
      busy_q        <= 1'b0;
      grant_b_q     <= 1'b1;
    end else begin
      a_ack_q       <= a_ack_d;
      b_ack_q       <= b_ack_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
      mem_raddr_q   <= mem_raddr_d;
      mem_waddr_q   <= mem_waddr_d;
      mem_write_q   <= mem_write_d;
      mem_data_in_q <= mem_data_in_d;
      busy_q        <= busy_d;
      grant_b_q     <= grant_b_d;
    end
  end

  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign mem_raddr   = mem_raddr_q;
  assign mem_waddr   = mem_waddr_q;
  assign mem_write   = mem_write_q;
  assign mem_data_in = mem_data_in_q;
  assign busy        = busy_q;
  assign grant_b     = grant_b_q;

endmodule
